tower_mem_arbiter: RTL and testbench

- Controller for the 32x32 calorimeter tower store. Each tower holds an et value and an e value, and the store is a single-port memory.
- Shares the single memory port between one loader (write) and NREQ clustering/readout requesters (read).
- Provides a hardware clear sweep that zeroes all 1024 towers between events.
- Sits between the event unpacker/loader and the downstream jet/seed finders.

---
 rtl/tower_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_tower_mem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tower_mem_arbiter.sv
// Single-port tower store controller: one loader write port, NREQ round-robin
// read requesters, and a hardware clear sweep over all ETA x PHI towers.
module tower_mem_arbiter #(
  parameter int NREQ  = 4,
  parameter int ETA_W = 5,
  parameter int PHI_W = 5,
  parameter int E_W   = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_start,
  output logic                      busy,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [ETA_W-1:0]          wr_eta,
  input  logic [PHI_W-1:0]          wr_phi,
  input  logic [E_W-1:0]            wr_et,
  input  logic [E_W-1:0]            wr_e,
  input  logic [NREQ-1:0]           rd_req,
  input  logic [NREQ*ETA_W-1:0]     rd_eta,
  input  logic [NREQ*PHI_W-1:0]     rd_phi,
  output logic [NREQ-1:0]           rd_gnt,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [E_W-1:0]            rsp_et,
  output logic [E_W-1:0]            rsp_e,
  output logic                      mem_we,
  output logic                      mem_re,
  output logic [ETA_W+PHI_W-1:0]    mem_addr,
  output logic [E_W-1:0]            mem_wet,
  output logic [E_W-1:0]            mem_we_data,
  input  logic [E_W-1:0]            mem_ret,
  input  logic [E_W-1:0]            mem_re_data
);

  localparam int ADDR_W = ETA_W + PHI_W;
  localparam int PTR_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [0:0] SERVE = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]  rsp_valid_q;

  logic             gnt_found;
  logic [PTR_W-1:0] gnt_idx;
  logic [ETA_W-1:0] sel_eta;
  logic [PHI_W-1:0] sel_phi;
  int               idx;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    gnt_found = 1'b0;
    gnt_idx   = '0;
    sel_eta   = '0;
    sel_phi   = '0;
    idx       = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NREQ;
      if (!gnt_found && rd_req[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(idx);
        sel_eta   = rd_eta[idx*ETA_W +: ETA_W];
        sel_phi   = rd_phi[idx*PHI_W +: PHI_W];
      end
    end
  end

  always_comb begin
    wr_ready    = 1'b0;
    rd_gnt      = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_addr    = '0;
    mem_wet     = '0;
    mem_we_data = '0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    // Memory-side strobes are forced quiet for as long as reset is held.
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_we   = 1'b1;
        mem_addr = cnt_q;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = SERVE;
          cnt_d   = '0;
        end
      end else if (clr_start) begin
        state_d = CLEAR;
      end else if (wr_valid) begin
        wr_ready    = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = {wr_phi, wr_eta};
        mem_wet     = wr_et;
        mem_we_data = wr_e;
      end else if (gnt_found) begin
        rd_gnt[gnt_idx] = 1'b1;
        mem_re          = 1'b1;
        mem_addr        = {sel_phi, sel_eta};
        rr_ptr_d        = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SERVE;
      cnt_q       <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rd_gnt;
    end
  end

  assign busy      = (state_q == CLEAR);
  assign rsp_valid = rsp_valid_q;
  assign rsp_et    = mem_ret;
  assign rsp_e     = mem_re_data;

endmodule

// File: tb/tb_tower_mem_arbiter.sv
// Directed bench for tower_mem_arbiter with a one-cycle-latency memory model.
module tb_tower_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_start;
  logic        busy;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_eta;
  logic [4:0]  wr_phi;
  logic [9:0]  wr_et;
  logic [9:0]  wr_e;
  logic [3:0]  rd_req;
  logic [19:0] rd_eta;
  logic [19:0] rd_phi;
  logic [3:0]  rd_gnt;
  logic [3:0]  rsp_valid;
  logic [9:0]  rsp_et;
  logic [9:0]  rsp_e;
  logic        mem_we;
  logic        mem_re;
  logic [9:0]  mem_addr;
  logic [9:0]  mem_wet;
  logic [9:0]  mem_we_data;
  logic [9:0]  mem_ret;
  logic [9:0]  mem_re_data;

  int checks = 0;
  int failures = 0;

  logic [9:0] store_et [0:1023];
  logic [9:0] store_e  [0:1023];

  always #5 clk = ~clk;

  tower_mem_arbiter dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .busy(busy),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_eta(wr_eta), .wr_phi(wr_phi),
    .wr_et(wr_et), .wr_e(wr_e), .rd_req(rd_req), .rd_eta(rd_eta), .rd_phi(rd_phi),
    .rd_gnt(rd_gnt), .rsp_valid(rsp_valid), .rsp_et(rsp_et), .rsp_e(rsp_e),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wet(mem_wet),
    .mem_we_data(mem_we_data), .mem_ret(mem_ret), .mem_re_data(mem_re_data)
  );

  // Single-port memory: write lands at the edge, read data appears the cycle after mem_re.
  always @(posedge clk) begin
    if (mem_we) begin
      store_et[mem_addr] <= mem_wet;
      store_e[mem_addr]  <= mem_we_data;
    end
    if (mem_re) begin
      mem_ret     <= store_et[mem_addr];
      mem_re_data <= store_e[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects the sweep to be in its first cycle at the next negedge; checks n cycles.
  task automatic run_clear(input int n);
    logic [37:0] exp_v;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      clr_start = 1'b0;
      #1;
      exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 10'd0, 10'd0, 10'(i)};
      check("clear_cycle", 64'({busy, mem_we, mem_re, wr_ready, rd_gnt, mem_wet, mem_we_data, mem_addr}),
            64'(exp_v));
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    rst = 1'b1; clr_start = 1'b0; wr_valid = 1'b0;
    wr_eta = '0; wr_phi = '0; wr_et = '0; wr_e = '0;
    rd_req = 4'b1111;
    rd_eta = {5'd13, 5'd12, 5'd11, 5'd10};
    rd_phi = {5'd3, 5'd2, 5'd1, 5'd0};

    // Reset with requests pending
    @(negedge clk); @(negedge clk); #1;
    check("reset_gnt",   64'(rd_gnt), 64'(4'b0000));
    check("reset_re",    64'(mem_re), 64'(1'b0));
    check("reset_addr",  64'(mem_addr), 64'(10'd0));
    check("reset_busy",  64'(busy), 64'(1'b0));
    check("reset_rsp",   64'(rsp_valid), 64'(4'b0000));

    @(negedge clk); rst = 1'b0; #1;
    check("pre_gnt0", 64'(rd_gnt), 64'(4'b0001));
    @(negedge clk); #1;
    check("pre_gnt1", 64'(rd_gnt), 64'(4'b0010));
    check("pre_rsp0", 64'(rsp_valid), 64'(4'b0001));
    @(negedge clk); rst = 1'b1; #1;
    check("midrst_gnt",  64'(rd_gnt), 64'(4'b0000));
    check("midrst_re",   64'(mem_re), 64'(1'b0));
    check("midrst_we",   64'(mem_we), 64'(1'b0));
    check("midrst_rdy",  64'(wr_ready), 64'(1'b0));
    check("midrst_addr", 64'(mem_addr), 64'(10'd0));
    check("midrst_rsp",  64'(rsp_valid), 64'(4'b0000));

    // Fairness after reset: pointer restarts at 0
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      exp_g = 4'b0001 << (c % 4);
      check("fair_gnt", 64'(rd_gnt), 64'(exp_g));
      check("fair_re", 64'(mem_re), 64'(1'b1));
      exp_g = (c == 0) ? 4'b0000 : 4'b0001 << ((c - 1) % 4);
      check("fair_rsp", 64'(rsp_valid), 64'(exp_g));
    end

    // Write (3,2) then read it back through requester 1
    @(negedge clk);
    rd_req = 4'b0000; wr_valid = 1'b1;
    wr_eta = 5'd3; wr_phi = 5'd2; wr_et = 10'd517; wr_e = 10'd900;
    #1;
    check("wr_ready", 64'(wr_ready), 64'(1'b1));
    check("wr_we",    64'(mem_we), 64'(1'b1));
    check("wr_addr",  64'(mem_addr), 64'(10'd67));
    check("wr_et",    64'(mem_wet), 64'(10'd517));
    check("wr_e",     64'(mem_we_data), 64'(10'd900));
    check("wr_gnt",   64'(rd_gnt), 64'(4'b0000));
    check("fair_last_rsp", 64'(rsp_valid), 64'(4'b1000));
    @(negedge clk);
    wr_valid = 1'b0; rd_req = 4'b0010;
    rd_eta[9:5] = 5'd3; rd_phi[9:5] = 5'd2;
    #1;
    check("raw_gnt",  64'(rd_gnt), 64'(4'b0010));
    check("raw_re",   64'(mem_re), 64'(1'b1));
    check("raw_addr", 64'(mem_addr), 64'(10'd67));
    @(negedge clk); rd_req = 4'b0000; #1;
    check("raw_rsp",    64'(rsp_valid), 64'(4'b0010));
    check("raw_rsp_et", 64'(rsp_et), 64'(10'd517));
    check("raw_rsp_e",  64'(rsp_e), 64'(10'd900));

    // Write beats a simultaneous read
    @(negedge clk);
    wr_valid = 1'b1; wr_eta = 5'd5; wr_phi = 5'd1; wr_et = 10'd100; wr_e = 10'd200;
    rd_req = 4'b0100; rd_eta[14:10] = 5'd5; rd_phi[14:10] = 5'd1;
    #1;
    check("prio_wr_ready", 64'(wr_ready), 64'(1'b1));
    check("prio_gnt",      64'(rd_gnt), 64'(4'b0000));
    check("prio_addr",     64'(mem_addr), 64'(10'd37));
    @(negedge clk); wr_valid = 1'b0; #1;
    check("prio_late_gnt",  64'(rd_gnt), 64'(4'b0100));
    check("prio_late_addr", 64'(mem_addr), 64'(10'd37));

    // clr_start beats a write; previous read still answers
    @(negedge clk);
    rd_req = 4'b0000; clr_start = 1'b1;
    wr_valid = 1'b1; wr_eta = 5'd7; wr_phi = 5'd7; wr_et = 10'd1; wr_e = 10'd1;
    #1;
    check("prio_rsp",    64'(rsp_valid), 64'(4'b0100));
    check("prio_rsp_et", 64'(rsp_et), 64'(10'd100));
    check("prio_rsp_e",  64'(rsp_e), 64'(10'd200));
    check("clr_start_rdy",  64'(wr_ready), 64'(1'b0));
    check("clr_start_we",   64'(mem_we), 64'(1'b0));
    check("clr_start_busy", 64'(busy), 64'(1'b0));

    // Full sweep with loader and requesters hammering
    rd_req = 4'b1111;
    run_clear(1024);
    @(negedge clk);
    wr_valid = 1'b0; rd_req = 4'b1010;
    rd_eta[19:15] = 5'd5; rd_phi[19:15] = 5'd1;
    #1;
    check("post_clr_busy", 64'(busy), 64'(1'b0));
    check("post_clr_gnt3", 64'(rd_gnt), 64'(4'b1000));
    check("post_clr_addr37", 64'(mem_addr), 64'(10'd37));
    @(negedge clk); rd_req = 4'b0010; #1;
    check("post_clr_gnt1",   64'(rd_gnt), 64'(4'b0010));
    check("post_clr_addr67", 64'(mem_addr), 64'(10'd67));
    check("post_clr_rsp3",   64'({rsp_valid, rsp_et, rsp_e}), 64'({4'b1000, 10'd0, 10'd0}));
    @(negedge clk); rd_req = 4'b0000; #1;
    check("post_clr_rsp1",   64'({rsp_valid, rsp_et, rsp_e}), 64'({4'b0010, 10'd0, 10'd0}));

    // Reset at sweep cycle 500, then a fresh full sweep
    @(negedge clk); clr_start = 1'b1; #1;
    check("clr2_start_busy", 64'(busy), 64'(1'b0));
    run_clear(501);
    rst = 1'b1; #1;
    check("clr_rst_busy", 64'(busy), 64'(1'b0));
    check("clr_rst_we",   64'(mem_we), 64'(1'b0));
    check("clr_rst_addr", 64'(mem_addr), 64'(10'd0));
    @(negedge clk); rst = 1'b0; #1;
    check("clr_rel_busy", 64'(busy), 64'(1'b0));
    check("clr_rel_we",   64'(mem_we), 64'(1'b0));
    @(negedge clk); clr_start = 1'b1; #1;
    check("clr3_start_busy", 64'(busy), 64'(1'b0));
    run_clear(1024);
    @(negedge clk); #1;
    check("clr3_end_busy", 64'(busy), 64'(1'b0));
    check("clr3_end_we",   64'(mem_we), 64'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
